// File: rtl/pasta_stream_decrypt.sv
// Purpose: PASTA keystream consumer. Sequences the permutation core (reset, nonce,
//          block counter), takes each S-word keystream block and subtracts it mod Q
//          from a streamed ciphertext, one word in, one registered plaintext word out.
// Ports:   clk/rst (sync, active-high); start/nonce begin a message; perm_* drive and
//          observe the permutation core; ct_* ciphertext in (valid/ready); pt_* plaintext
//          out (valid/ready); busy spans start..last word accepted; err flags ct >= Q.
// Config:  define PASTA_KS_PREFETCH_EN to buffer the keystream and overlap computing
//          block n+1 with streaming block n; otherwise perm_ks is read live from the core.
module pasta_stream_decrypt #(
  parameter int BITLEN = 17,
  parameter int Q      = 65537,
  parameter int S      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [63:0]         nonce,
  output logic                perm_rst,
  output logic [63:0]         perm_nonce,
  output logic [63:0]         perm_block_counter,
  input  logic                perm_done,
  input  logic [BITLEN*S-1:0] perm_ks,
  input  logic                ct_valid,
  output logic                ct_ready,
  input  logic [BITLEN-1:0]   ct_data,
  input  logic                ct_last,
  output logic                pt_valid,
  input  logic                pt_ready,
  output logic [BITLEN-1:0]   pt_data,
  output logic                pt_last,
  output logic                busy,
  output logic                err
);

  localparam int IDXW = (S > 1) ? $clog2(S) : 1;
  localparam logic [BITLEN:0] Q_EXT = (BITLEN+1)'(Q);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, STREAM, FLUSH} state_t;

  state_t            state, state_nx;
  logic [IDXW-1:0]   idx;
  logic [63:0]       blk_ctr;
  logic [63:0]       nonce_q;
  logic [BITLEN-1:0] ks_word;
  logic [BITLEN:0]   diff;
  logic              ct_fire;
  logic              pt_fire;
  logic              blk_end;
  logic              ks_avail;
  // High for the single cycle in which the core is being re-armed behind the stream.
  // perm_done may still show the previous block during that cycle, so it is masked.
  logic              rearm;

  assign perm_nonce         = nonce_q;
  assign perm_block_counter = blk_ctr;
  assign ct_fire            = ct_valid && ct_ready;
  assign pt_fire            = pt_valid && pt_ready;
  assign blk_end            = ct_fire && !ct_last && (idx == IDXW'(S-1));
  assign ks_avail           = perm_done && !rearm;

`ifdef PASTA_KS_PREFETCH_EN
  logic [BITLEN-1:0] ks_buf [S];
  logic              capture;

  // Capture either the first block (WAIT) or, at a block boundary, a prefetch that has
  // already completed. Every capture immediately re-arms the core for the next block.
  assign capture = ks_avail && ((state == WAIT) || (state == STREAM && blk_end));
  assign ks_word = ks_buf[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      rearm <= 1'b0;
    end else begin
      rearm <= capture;
    end
    if (capture) begin
      for (int i = 0; i < S; i++) begin
        ks_buf[i] <= perm_ks[BITLEN*i +: BITLEN];
      end
    end
  end
`else
  // The core holds perm_ks after perm_done while perm_rst stays low, so read it live.
  assign rearm   = 1'b0;
  assign ks_word = perm_ks[BITLEN*idx +: BITLEN];
`endif

  // ct - ks mod Q; the +Q branch cannot overflow BITLEN+1 bits since ct < ks there.
  assign diff = (ct_data >= ks_word) ? {1'b0, ct_data - ks_word}
                                     : ({1'b0, ct_data} + Q_EXT - {1'b0, ks_word});

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (start) state_nx = LOAD;
      LOAD:   state_nx = WAIT;
      WAIT:   if (ks_avail) state_nx = STREAM;
      STREAM: begin
        if (ct_fire && ct_last) begin
          state_nx = FLUSH;
        end else if (blk_end) begin
`ifdef PASTA_KS_PREFETCH_EN
          state_nx = ks_avail ? STREAM : WAIT;
`else
          state_nx = LOAD;
`endif
        end
      end
      FLUSH:  if (pt_fire && pt_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    perm_rst = 1'b1;
    ct_ready = 1'b0;
    case (state)
      WAIT:   perm_rst = rearm;
      STREAM: begin
        perm_rst = rearm;
        ct_ready = !pt_valid || pt_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nonce_q  <= '0;
      blk_ctr  <= '0;
      idx      <= '0;
      pt_valid <= 1'b0;
      pt_data  <= '0;
      pt_last  <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        nonce_q <= nonce;
        blk_ctr <= '0;
        idx     <= '0;
        busy    <= 1'b1;
        err     <= 1'b0;
      end

      if (ct_fire) begin
        idx <= blk_end ? '0 : idx + 1'b1;
        if ({1'b0, ct_data} >= Q_EXT) err <= 1'b1;
      end

`ifdef PASTA_KS_PREFETCH_EN
      // Counter names the block the core is working on, which runs one ahead.
      if (capture) blk_ctr <= blk_ctr + 64'd1;
`else
      if (blk_end) blk_ctr <= blk_ctr + 64'd1;
`endif

      if (ct_fire) begin
        pt_valid <= 1'b1;
        pt_data  <= diff[BITLEN-1:0];
        pt_last  <= ct_last;
      end else if (pt_ready) begin
        pt_valid <= 1'b0;
        pt_last  <= 1'b0;
      end

      if (state == FLUSH && pt_fire && pt_last) busy <= 1'b0;
    end
  end

endmodule
